// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//
// Packet-level round-robin arbiter sharing one valid/ready sink between NUM_SRC sources.
// A grant is held from the first beat of a packet until the beat with s_last=1. The next
// winner is chosen on that closing handshake, so back-to-back packets flow without a bubble.
//
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   s_valid  per-source valid (bit i = source i)
//   s_ready  per-source ready; only the granted bit can be high, and it follows m_ready
//   s_data   flattened source data, source i at [i*SIZE +: SIZE]
//   s_last   per-source end-of-packet flag
//   m_valid  arbitrated valid toward the sink
//   m_ready  sink ready
//   m_data   data of the granted source (last presented value while idle)
//   m_last   s_last of the granted source
//   m_src    index of the granted source
//   busy     high while a grant is held

module stream_rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SIZE    = 32,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_SRC-1:0]      s_valid,
    output logic [NUM_SRC-1:0]      s_ready,
    input  logic [NUM_SRC*SIZE-1:0] s_data,
    input  logic [NUM_SRC-1:0]      s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SIZE-1:0]         m_data,
    output logic                    m_last,
    output logic [SRC_W-1:0]        m_src,
    output logic                    busy
);

    typedef enum logic {StIdle, StLock} state_e;

    state_e            state_q;
    logic [SRC_W-1:0]  grant_q;
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [SIZE-1:0]   data_hold_q;

    logic              lock;
    logic              sel_valid;
    logic              sel_last;
    logic [SIZE-1:0]   sel_data;
    logic [NUM_SRC-1:0] others;
    logic              closing;

    // First set bit of req scanning ptr+1, ptr+2, ... modulo NUM_SRC; ptr itself is last.
    function automatic logic [SRC_W-1:0] pick(input logic [SRC_W-1:0]   ptr,
                                              input logic [NUM_SRC-1:0] req);
        logic [SRC_W-1:0] res;
        logic [SRC_W-1:0] idx;
        logic             found;
        int unsigned      sum;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            sum = 32'(ptr) + k;
            idx = SRC_W'(sum % NUM_SRC);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign lock      = (state_q == StLock);
    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];
    assign sel_data  = s_data[32'(grant_q) * SIZE +: SIZE];
    assign others    = s_valid & ~(NUM_SRC'(1) << grant_q);
    assign closing   = lock && sel_valid && m_ready && sel_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= SRC_W'(NUM_SRC - 1);
            data_hold_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|s_valid) begin
                        grant_q <= pick(rr_ptr_q, s_valid);
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    data_hold_q <= sel_data;
                    if (closing) begin
                        rr_ptr_q <= grant_q;
                        if (|others) begin
                            grant_q <= pick(grant_q, others);
                        end else if (!sel_valid) begin
                            // Granted valid is high on any handshake, so a lone requester
                            // keeps the grant; this return to idle is a safety net only.
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    // s_ready follows m_ready combinationally so a beat moves every cycle the sink accepts.
    always_comb begin
        s_ready = '0;
        if (lock) begin
            s_ready[grant_q] = m_ready;
        end
        m_valid = lock && sel_valid;
        m_last  = lock && sel_last;
        m_data  = lock ? sel_data : data_hold_q;
        m_src   = grant_q;
        busy    = lock;
    end

endmodule
